// File: rtl/multi_first_detector.sv
// ---------------------------------------------------------------------------
// multi_first_detector
//   N-channel first-signal detector. A pulse on arm opens a detection window
//   (ARMED). The first cycle on which any channel shows a rising edge closes
//   the window and captures the lowest-numbered rising channel as the winner.
//   Also reported: a tie flag (several channels rose on that cycle) and the
//   number of ARMED cycles that passed. An optional timeout closes the window
//   if no edge arrives.
//   The one-hot y output keeps the convention of the older 3-input a/b/c
//   detector.
//
// Configuration macro:
//   SYNC_INPUTS_EN - when defined, each sig bit passes through a 2-flop
//                    synchroniser before edge detection. This adds 2 cycles
//                    of latency and lets sig be asynchronous to clk. When it
//                    is undefined, sig must already be synchronous to clk.
//
// Parameters:
//   N        number of channels (>= 2)
//   CNT_W    width of the elapsed counter
//   TIMEOUT  number of ARMED cycles before giving up; 0 disables the timeout
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   arm         start or restart detection
//   clear       return to IDLE and clear the results; takes priority over arm
//   sig         channel inputs [N-1:0]
//   y           one-hot winning channel (0 when there is none)
//   winner_idx  binary index of the winner
//   valid       winner captured; held until arm, clear or rst
//   tie         more than one channel rose on the winning cycle
//   timeout     window closed by the timeout with no edge
//   busy        high while ARMED
//   elapsed     ARMED cycles before detection or timeout (saturating)
//   state_dbg   current FSM state (0 IDLE, 1 ARMED, 2 DONE)
//
// Handshake: arm and clear are single-cycle command pulses sampled on every
// posedge, with no back-pressure. valid is a level that stays high from the
// cycle after the winning edge until the next arm, clear or reset.
// ---------------------------------------------------------------------------
module multi_first_detector #(
    parameter int N       = 3,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000,
    localparam int IDX_W  = (N > 2) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             clear,
    input  logic [N-1:0]     sig,
    output logic [N-1:0]     y,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid,
    output logic             tie,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] elapsed,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);

    state_t           state;
    logic [N-1:0]     sig_s;
    logic [N-1:0]     prev;
    logic [N-1:0]     rise;
    logic [N-1:0]     first_onehot;
    logic [IDX_W-1:0] first_idx;
    logic             multi;

`ifdef SYNC_INPUTS_EN
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
        end
    end

    assign sig_s = sync2;
`else
    assign sig_s = sig;
`endif

    assign rise = sig_s & ~prev;

    // Isolate the lowest set bit. Clearing that bit leaves something nonzero
    // only when more than one channel rose.
    assign first_onehot = rise & (~rise + N'(1));
    assign multi        = |(rise & (rise - N'(1)));

    always_comb begin
        first_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rise[i]) first_idx = IDX_W'(i);
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prev       <= '0;
            y          <= '0;
            winner_idx <= '0;
            valid      <= 1'b0;
            tie        <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
            elapsed    <= '0;
        end else begin
            // The edge history tracks the input in every state. A channel that
            // is already high when arm arrives therefore shows no edge.
            prev <= sig_s;
            if (clear) begin
                state      <= IDLE;
                y          <= '0;
                winner_idx <= '0;
                valid      <= 1'b0;
                tie        <= 1'b0;
                timeout    <= 1'b0;
                busy       <= 1'b0;
                elapsed    <= '0;
            end else if (arm) begin
                state      <= ARMED;
                y          <= '0;
                winner_idx <= '0;
                valid      <= 1'b0;
                tie        <= 1'b0;
                timeout    <= 1'b0;
                busy       <= 1'b1;
                elapsed    <= '0;
            end else if (state == ARMED) begin
                if (|rise) begin
                    state      <= DONE;
                    y          <= first_onehot;
                    winner_idx <= first_idx;
                    valid      <= 1'b1;
                    tie        <= multi;
                    busy       <= 1'b0;
                end else if (TIMEOUT_EN && (elapsed == TO_LAST)) begin
                    state   <= DONE;
                    timeout <= 1'b1;
                    busy    <= 1'b0;
                    elapsed <= TO_VAL;
                end else if (elapsed != '1) begin
                    elapsed <= elapsed + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_first_detector.sv
module tb_multi_first_detector;

`ifdef SYNC_INPUTS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] sig = 3'b000;

    // dut1: N=3, 16-bit counter, TIMEOUT=8
    logic [2:0]  d1_y;
    logic [1:0]  d1_idx;
    logic        d1_valid, d1_tie, d1_to, d1_busy;
    logic [15:0] d1_el;
    logic [1:0]  d1_st;
    // dut2: N=3, 3-bit counter, timeout disabled (exercises saturation)
    logic [2:0]  d2_y;
    logic [1:0]  d2_idx;
    logic        d2_valid, d2_tie, d2_to, d2_busy;
    logic [2:0]  d2_el;
    logic [1:0]  d2_st;

    multi_first_detector #(.N(3), .CNT_W(16), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear), .sig(sig),
        .y(d1_y), .winner_idx(d1_idx), .valid(d1_valid), .tie(d1_tie),
        .timeout(d1_to), .busy(d1_busy), .elapsed(d1_el), .state_dbg(d1_st)
    );

    multi_first_detector #(.N(3), .CNT_W(3), .TIMEOUT(0)) dut2 (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear), .sig(sig),
        .y(d2_y), .winner_idx(d2_idx), .valid(d2_valid), .tie(d2_tie),
        .timeout(d2_to), .busy(d2_busy), .elapsed(d2_el), .state_dbg(d2_st)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    // hist holds the sig value seen at each posedge since reset, with zeros
    // prefilled to stand in for the reset history.
    int         to_p [2] = '{8, 0};
    int         sat  [2] = '{65535, 7};
    logic [2:0] hist[$];
    int         m_ph [2];   // 0 waiting, 1 window open, 2 finished
    int         m_y  [2];
    int         m_idx[2];
    int         m_val[2];
    int         m_tie[2];
    int         m_to [2];
    int         m_el [2];

    task automatic model_reset();
        hist = {};
        repeat (LAT + 1) hist.push_back(3'b000);
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = 0; m_y[d] = 0; m_idx[d] = 0; m_val[d] = 0;
            m_tie[d] = 0; m_to[d] = 0; m_el[d] = 0;
        end
    endtask

    task automatic model_step(input logic a, input logic c, input logic [2:0] s);
        logic [2:0] now_v, before_v, r;
        int first;
        hist.push_back(s);
        now_v    = hist[hist.size() - 1 - LAT];
        before_v = hist[hist.size() - 2 - LAT];
        void'(hist.pop_front());
        r = now_v & ~before_v;
        first = -1;
        for (int i = 2; i >= 0; i--) if (r[i]) first = i;
        for (int d = 0; d < 2; d++) begin
            if (c) begin
                m_ph[d] = 0; m_y[d] = 0; m_idx[d] = 0; m_val[d] = 0;
                m_tie[d] = 0; m_to[d] = 0; m_el[d] = 0;
            end else if (a) begin
                m_ph[d] = 1; m_y[d] = 0; m_idx[d] = 0; m_val[d] = 0;
                m_tie[d] = 0; m_to[d] = 0; m_el[d] = 0;
            end else if (m_ph[d] == 1) begin
                if (first >= 0) begin
                    m_ph[d] = 2; m_y[d] = 1 << first; m_idx[d] = first;
                    m_val[d] = 1; m_tie[d] = ($countones(r) > 1) ? 1 : 0;
                end else if (to_p[d] != 0 && m_el[d] == to_p[d] - 1) begin
                    m_ph[d] = 2; m_to[d] = 1; m_el[d] = to_p[d];
                end else if (m_el[d] < sat[d]) begin
                    m_el[d] = m_el[d] + 1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d1_y",       32'(d1_y),     32'(m_y[0]));
        chk("d1_idx",     32'(d1_idx),   32'(m_idx[0]));
        chk("d1_valid",   32'(d1_valid), 32'(m_val[0]));
        chk("d1_tie",     32'(d1_tie),   32'(m_tie[0]));
        chk("d1_timeout", 32'(d1_to),    32'(m_to[0]));
        chk("d1_busy",    32'(d1_busy),  32'(m_ph[0] == 1));
        chk("d1_elapsed", 32'(d1_el),    32'(m_el[0]));
        chk("d2_y",       32'(d2_y),     32'(m_y[1]));
        chk("d2_idx",     32'(d2_idx),   32'(m_idx[1]));
        chk("d2_valid",   32'(d2_valid), 32'(m_val[1]));
        chk("d2_tie",     32'(d2_tie),   32'(m_tie[1]));
        chk("d2_timeout", 32'(d2_to),    32'(m_to[1]));
        chk("d2_busy",    32'(d2_busy),  32'(m_ph[1] == 1));
        chk("d2_elapsed", 32'(d2_el),    32'(m_el[1]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic a, input logic c, input logic [2:0] s);
        @(negedge clk);
        arm = a; clear = c; sig = s;
        @(posedge clk);
        model_step(a, c, s);
        #1;
        check_all();
    endtask

    task automatic settle(input logic [2:0] s);
        repeat (LAT + 2) tick(1'b0, 1'b0, s);
    endtask

    // Drop reset between edges, with sig still moving, and release it later.
    task automatic async_reset();
        #2;
        sig = ~sig;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_busy_now", 32'(d1_busy), 32'd0);
        chk("rst_state",    32'(d1_st),   32'd0);
        repeat (2) begin
            @(negedge clk);
            sig = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        rst = 1'b1; arm = 1'b0; clear = 1'b0;
        @(posedge clk);
        model_step(1'b0, 1'b0, sig);
        #1;
        check_all();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();
        #2 rst = 1'b0;
        #1 check_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_step(1'b0, 1'b0, 3'b000);
        #1 check_all();

        // Winner on the 5th posedge after arm; a later edge changes nothing.
        settle(3'b000);
        tick(1'b1, 1'b0, 3'b000);
        repeat (4) tick(1'b0, 1'b0, 3'b000);
        tick(1'b0, 1'b0, 3'b010);
        repeat (LAT) tick(1'b0, 1'b0, 3'b010);
        chk("t2_y",       32'(d1_y),     32'b010);
        chk("t2_idx",     32'(d1_idx),   32'd1);
        chk("t2_valid",   32'(d1_valid), 32'd1);
        chk("t2_tie",     32'(d1_tie),   32'd0);
        chk("t2_elapsed", 32'(d1_el),    32'(4 + LAT));
        repeat (LAT + 1) tick(1'b0, 1'b0, 3'b011);
        chk("t2_hold_y",  32'(d1_y),     32'b010);

        // Two channels rise together: lowest wins, tie flagged.
        settle(3'b000);
        tick(1'b1, 1'b0, 3'b000);
        tick(1'b0, 1'b0, 3'b101);
        repeat (LAT) tick(1'b0, 1'b0, 3'b101);
        chk("t3_y",   32'(d1_y),   32'b001);
        chk("t3_idx", 32'(d1_idx), 32'd0);
        chk("t3_tie", 32'(d1_tie), 32'd1);

        // Channel already high at arm cannot win.
        settle(3'b100);
        tick(1'b1, 1'b0, 3'b100);
        repeat (2) tick(1'b0, 1'b0, 3'b100);
        tick(1'b0, 1'b0, 3'b101);
        repeat (LAT) tick(1'b0, 1'b0, 3'b101);
        chk("t4_y",   32'(d1_y),   32'b001);
        chk("t4_tie", 32'(d1_tie), 32'd0);

        // Timeout on the 8th posedge after arm.
        settle(3'b000);
        tick(1'b1, 1'b0, 3'b000);
        repeat (8) tick(1'b0, 1'b0, 3'b000);
        chk("t5_timeout", 32'(d1_to),    32'd1);
        chk("t5_valid",   32'(d1_valid), 32'd0);
        chk("t5_elapsed", 32'(d1_el),    32'd8);
        chk("t5_busy",    32'(d1_busy),  32'd0);

        // Edge on that same posedge beats the timeout.
        settle(3'b000);
        tick(1'b1, 1'b0, 3'b000);
        for (int k = 1; k <= 8; k++)
            tick(1'b0, 1'b0, (k >= 8 - LAT) ? 3'b001 : 3'b000);
        chk("t5e_valid",   32'(d1_valid), 32'd1);
        chk("t5e_timeout", 32'(d1_to),    32'd0);
        chk("t5e_elapsed", 32'(d1_el),    32'd7);

        // clear and arm together in DONE; then re-arm mid-window.
        tick(1'b1, 1'b1, 3'b001);
        chk("t6_valid", 32'(d1_valid), 32'd0);
        chk("t6_busy",  32'(d1_busy),  32'd0);
        chk("t6_state", 32'(d1_st),    32'd0);
        tick(1'b1, 1'b0, 3'b001);
        repeat (3) tick(1'b0, 1'b0, 3'b001);
        tick(1'b1, 1'b0, 3'b001);
        chk("t6_rearm_el",   32'(d1_el),   32'd0);
        chk("t6_rearm_busy", 32'(d1_busy), 32'd1);

        // Counter saturation in the 3-bit instance.
        repeat (10) tick(1'b0, 1'b0, 3'b001);
        chk("sat_el",   32'(d2_el),   32'd7);
        chk("sat_busy", 32'(d2_busy), 32'd1);

        // Async reset while ARMED with sig toggling.
        settle(3'b000);
        tick(1'b1, 1'b0, 3'b000);
        tick(1'b0, 1'b0, 3'b000);
        async_reset();

        // Random traffic with one reset in the middle.
        for (int n = 0; n < 400; n++) begin
            logic       a, c;
            logic [2:0] s;
            a = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : sig;
            tick(a, c, s);
            if (n == 200) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
